// File: rtl/nes_pkg.sv
// Shared types and constants for the iNES image loader.
// Header layout, bank sizes and the loader state encoding live here.
package nes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StTrainer,
    StPrg,
    StChr,
    StDone,
    StError
  } load_state_e;

  // "NES\x1A" with byte 0 in the least significant position
  localparam logic [31:0] INES_MAGIC = 32'h1A53_454E;

  localparam int unsigned HEADER_BYTES  = 16;
  localparam int unsigned HDR_PRG_BANKS = 4;
  localparam int unsigned HDR_CHR_BANKS = 5;
  localparam int unsigned HDR_FLAGS6    = 6;
  localparam int unsigned HDR_FLAGS7    = 7;

  localparam int unsigned FLAG_MIRROR  = 0;
  localparam int unsigned FLAG_TRAINER = 2;

  localparam int unsigned PRG_BANK_BYTES = 16384;
  localparam int unsigned CHR_BANK_BYTES = 8192;
  localparam int unsigned TRAINER_BYTES  = 512;

  function automatic int unsigned cnt_width(input int unsigned prg_depth,
                                            input int unsigned chr_depth);
    int unsigned w;
    w = (prg_depth > chr_depth) ? prg_depth : chr_depth;
    if (w < 9) w = 9;
    return w + 1;
  endfunction

endpackage

// File: rtl/ines_header.sv
// Captures the iNES header bytes as they stream past and decodes the
// cartridge fields plus a pass/fail verdict against the ROM capacities.
module ines_header
  import nes_pkg::*;
#(
  parameter int unsigned PRG_ROM_DEPTH = 15,
  parameter int unsigned CHR_ROM_DEPTH = 13
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [3:0] idx_i,
  input  logic [7:0] data_i,
  output logic [7:0] mapper_o,
  output logic       mirrorv_o,
  output logic       trainer_o,
  output logic [7:0] prg_banks_o,
  output logic [7:0] chr_banks_o,
  output logic       valid_o
);

  localparam int unsigned PrgMaxBanks = 1 << (PRG_ROM_DEPTH - 14);
  localparam int unsigned ChrMaxBanks = 1 << (CHR_ROM_DEPTH - 13);

  logic [31:0] magic_q;
  logic [7:0]  prg_q, chr_q;
  logic [3:0]  mapper_lo_q, mapper_hi_q;
  logic        mirror_q, trainer_q;

  // Bytes 8-15 carry nothing the NROM loader uses, so only 0-7 are kept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      magic_q     <= '0;
      prg_q       <= '0;
      chr_q       <= '0;
      mapper_lo_q <= '0;
      mapper_hi_q <= '0;
      mirror_q    <= 1'b0;
      trainer_q   <= 1'b0;
    end else if (we_i) begin
      case (idx_i)
        4'd0, 4'd1, 4'd2, 4'd3: magic_q[8*idx_i[1:0] +: 8] <= data_i;
        4'(HDR_PRG_BANKS):      prg_q <= data_i;
        4'(HDR_CHR_BANKS):      chr_q <= data_i;
        4'(HDR_FLAGS6): begin
          mapper_lo_q <= data_i[7:4];
          mirror_q    <= data_i[FLAG_MIRROR];
          trainer_q   <= data_i[FLAG_TRAINER];
        end
        4'(HDR_FLAGS7):         mapper_hi_q <= data_i[7:4];
        default: ;
      endcase
    end
  end

  assign mapper_o    = {mapper_hi_q, mapper_lo_q};
  assign mirrorv_o   = mirror_q;
  assign trainer_o   = trainer_q;
  assign prg_banks_o = prg_q;
  assign chr_banks_o = chr_q;
  assign valid_o     = (magic_q == INES_MAGIC) && (prg_q != 8'd0) &&
                       (32'(prg_q) <= PrgMaxBanks) && (32'(chr_q) <= ChrMaxBanks);

endmodule

// File: rtl/ines_loader.sv
// Streams an iNES image into the NROM PRG/CHR ROM write ports, publishing the
// decoded cartridge configuration and holding the cartridge in reset until done.
module ines_loader
  import nes_pkg::*;
#(
  parameter int unsigned PRG_ROM_DEPTH = 15,
  parameter int unsigned CHR_ROM_DEPTH = 13
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     prg_we,
  output logic [PRG_ROM_DEPTH-1:0] prg_addr,
  output logic [7:0]               prg_wdata,
  output logic                     chr_we,
  output logic [CHR_ROM_DEPTH-1:0] chr_addr,
  output logic [7:0]               chr_wdata,
  output logic [7:0]               mapper,
  output logic                     mirrorv,
  output logic [7:0]               prg_banks,
  output logic [7:0]               chr_banks,
  output logic                     cart_rst,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned CntW = cnt_width(PRG_ROM_DEPTH, CHR_ROM_DEPTH);
  localparam logic [CntW-1:0] HdrLast     = CntW'(HEADER_BYTES - 1);
  localparam logic [CntW-1:0] TrainerLast = CntW'(TRAINER_BYTES - 1);

  load_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic prg_we_q, prg_we_d, chr_we_q, chr_we_d;
  logic [PRG_ROM_DEPTH-1:0] prg_addr_q, prg_addr_d;
  logic [CHR_ROM_DEPTH-1:0] chr_addr_q, chr_addr_d;
  logic [7:0] prg_wdata_q, prg_wdata_d, chr_wdata_q, chr_wdata_d;
  logic [7:0] mapper_q, mapper_d, prg_banks_q, prg_banks_d, chr_banks_q, chr_banks_d;
  logic mirrorv_q, mirrorv_d;

  logic       accept, hdr_we;
  logic [7:0] hdr_mapper, hdr_prg_banks, hdr_chr_banks;
  logic       hdr_mirrorv, hdr_trainer, hdr_valid;
  logic [CntW-1:0] prg_len, chr_len;

  ines_header #(
    .PRG_ROM_DEPTH(PRG_ROM_DEPTH),
    .CHR_ROM_DEPTH(CHR_ROM_DEPTH)
  ) u_header (
    .clk_i      (clk_cpu),
    .rst_i      (rst),
    .we_i       (hdr_we),
    .idx_i      (cnt_q[3:0]),
    .data_i     (in_data),
    .mapper_o   (hdr_mapper),
    .mirrorv_o  (hdr_mirrorv),
    .trainer_o  (hdr_trainer),
    .prg_banks_o(hdr_prg_banks),
    .chr_banks_o(hdr_chr_banks),
    .valid_o    (hdr_valid)
  );

  assign in_ready = (state_q == StHeader) || (state_q == StTrainer) ||
                    (state_q == StPrg) || (state_q == StChr);
  assign accept   = in_valid && in_ready;
  assign hdr_we   = accept && (state_q == StHeader);

  // Bank counts were range-checked at validation, so these lengths fit in CntW
  assign prg_len = CntW'(prg_banks_q) * CntW'(PRG_BANK_BYTES);
  assign chr_len = CntW'(chr_banks_q) * CntW'(CHR_BANK_BYTES);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prg_we_d    = 1'b0;
    prg_addr_d  = prg_addr_q;
    prg_wdata_d = prg_wdata_q;
    chr_we_d    = 1'b0;
    chr_addr_d  = chr_addr_q;
    chr_wdata_d = chr_wdata_q;
    mapper_d    = mapper_q;
    mirrorv_d   = mirrorv_q;
    prg_banks_d = prg_banks_q;
    chr_banks_d = chr_banks_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d     = StHeader;
          cnt_d       = '0;
          mapper_d    = '0;
          mirrorv_d   = 1'b0;
          prg_banks_d = '0;
          chr_banks_d = '0;
        end
      end
      StHeader: begin
        if (accept) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == HdrLast) begin
            cnt_d       = '0;
            mapper_d    = hdr_mapper;
            mirrorv_d   = hdr_mirrorv;
            prg_banks_d = hdr_prg_banks;
            chr_banks_d = hdr_chr_banks;
            if (!hdr_valid)       state_d = StError;
            else if (hdr_trainer) state_d = StTrainer;
            else                  state_d = StPrg;
          end
        end
      end
      StTrainer: begin
        if (accept) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == TrainerLast) begin
            cnt_d   = '0;
            state_d = StPrg;
          end
        end
      end
      StPrg: begin
        if (accept) begin
          prg_we_d    = 1'b1;
          prg_addr_d  = cnt_q[PRG_ROM_DEPTH-1:0];
          prg_wdata_d = in_data;
          cnt_d       = cnt_q + CntW'(1);
          if (cnt_q == prg_len - CntW'(1)) begin
            cnt_d   = '0;
            state_d = (chr_banks_q != 8'd0) ? StChr : StDone;
          end
        end
      end
      StChr: begin
        if (accept) begin
          chr_we_d    = 1'b1;
          chr_addr_d  = cnt_q[CHR_ROM_DEPTH-1:0];
          chr_wdata_d = in_data;
          cnt_d       = cnt_q + CntW'(1);
          if (cnt_q == chr_len - CntW'(1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prg_we_q    <= 1'b0;
      prg_addr_q  <= '0;
      prg_wdata_q <= '0;
      chr_we_q    <= 1'b0;
      chr_addr_q  <= '0;
      chr_wdata_q <= '0;
      mapper_q    <= '0;
      mirrorv_q   <= 1'b0;
      prg_banks_q <= '0;
      chr_banks_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prg_we_q    <= prg_we_d;
      prg_addr_q  <= prg_addr_d;
      prg_wdata_q <= prg_wdata_d;
      chr_we_q    <= chr_we_d;
      chr_addr_q  <= chr_addr_d;
      chr_wdata_q <= chr_wdata_d;
      mapper_q    <= mapper_d;
      mirrorv_q   <= mirrorv_d;
      prg_banks_q <= prg_banks_d;
      chr_banks_q <= chr_banks_d;
    end
  end

  assign prg_we    = prg_we_q;
  assign prg_addr  = prg_addr_q;
  assign prg_wdata = prg_wdata_q;
  assign chr_we    = chr_we_q;
  assign chr_addr  = chr_addr_q;
  assign chr_wdata = chr_wdata_q;
  assign mapper    = mapper_q;
  assign mirrorv   = mirrorv_q;
  assign prg_banks = prg_banks_q;
  assign chr_banks = chr_banks_q;
  assign done      = (state_q == StDone);
  assign error     = (state_q == StError);
  assign cart_rst  = (state_q != StDone);

endmodule

// File: tb/tb_ines_loader.sv
// Bench for ines_loader: an image model predicts where every accepted byte
// must land; a per-cycle compare process checks the write ports against it.
module tb_ines_loader;

  localparam int PrgDepth = 15;
  localparam int ChrDepth = 13;

  logic                clk_cpu = 1'b0;
  logic                rst, start, in_valid;
  logic [7:0]          in_data;
  logic                in_ready, prg_we, chr_we, mirrorv, cart_rst, done, error;
  logic [PrgDepth-1:0] prg_addr;
  logic [ChrDepth-1:0] chr_addr;
  logic [7:0]          prg_wdata, chr_wdata, mapper, prg_banks, chr_banks;

  always #5 clk_cpu = ~clk_cpu;

  ines_loader #(
    .PRG_ROM_DEPTH(PrgDepth),
    .CHR_ROM_DEPTH(ChrDepth)
  ) dut (
    .clk_cpu  (clk_cpu),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .prg_we   (prg_we),
    .prg_addr (prg_addr),
    .prg_wdata(prg_wdata),
    .chr_we   (chr_we),
    .chr_addr (chr_addr),
    .chr_wdata(chr_wdata),
    .mapper   (mapper),
    .mirrorv  (mirrorv),
    .prg_banks(prg_banks),
    .chr_banks(chr_banks),
    .cart_rst (cart_rst),
    .done     (done),
    .error    (error)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Image model: header bytes plus a payload pattern derived from the byte offset
  logic [7:0] m_hdr [16];
  logic [7:0] m_seed;
  bit         m_ok;
  int         m_tr, m_prg, m_chr, m_len;

  function automatic logic [7:0] img_byte(input int k);
    logic [31:0] kk;
    kk = k;
    if (k < 16) return m_hdr[k];
    return kk[7:0] ^ kk[15:8] ^ m_seed;
  endfunction

  task automatic set_image(input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] b6, input logic [7:0] b7, input logic [7:0] seed);
    m_hdr[0] = 8'h4E; m_hdr[1] = 8'h45; m_hdr[2] = 8'h53; m_hdr[3] = b3;
    m_hdr[4] = b4;    m_hdr[5] = b5;    m_hdr[6] = b6;    m_hdr[7] = b7;
    for (int i = 8; i < 16; i++) m_hdr[i] = 8'h00;
    m_seed = seed;
    m_ok   = (b3 == 8'h1A) && (b4 != 8'd0) && (int'(b4) <= (1 << (PrgDepth - 14))) &&
             (int'(b5) <= (1 << (ChrDepth - 13)));
    m_tr   = b6[2] ? 512 : 0;
    m_prg  = int'(b4) * 16384;
    m_chr  = int'(b5) * 8192;
    m_len  = m_ok ? 16 + m_tr + m_prg + m_chr : 16;
  endtask

  // Index of the byte offered and accepted in the current cycle, -1 if none
  int          acc_idx = -1;
  int          n_prg, n_chr;
  logic [31:0] last_prg, last_chr, first_prg_data;

  task automatic clr_obs();
    n_prg = 0; n_chr = 0; last_prg = 0; last_chr = 0; first_prg_data = 32'hFFFF_FFFF;
  endtask

  initial begin : compare
    int   cur, off;
    logic r, exp_p, exp_c;
    forever begin
      @(posedge clk_cpu);
      cur = acc_idx;
      r   = rst;
      #1;
      off   = cur - 16 - m_tr;
      exp_p = !r && m_ok && cur >= 0 && off >= 0 && off < m_prg;
      exp_c = !r && m_ok && cur >= 0 && off >= m_prg && off < m_prg + m_chr;
      chk("prg_we", {31'd0, prg_we}, {31'd0, exp_p});
      chk("chr_we", {31'd0, chr_we}, {31'd0, exp_c});
      if (exp_p) begin
        chk("prg_addr", 32'(prg_addr), off);
        chk("prg_wdata", 32'(prg_wdata), 32'(img_byte(cur)));
        if (off == 0) first_prg_data = 32'(prg_wdata);
      end
      if (exp_c) begin
        chk("chr_addr", 32'(chr_addr), off - m_prg);
        chk("chr_wdata", 32'(chr_wdata), 32'(img_byte(cur)));
      end
      if (prg_we) begin n_prg++; last_prg = 32'(prg_addr); end
      if (chr_we) begin n_chr++; last_chr = 32'(chr_addr); end
    end
  end

  // Pulses start, then offers the image byte by byte; abort_at >= 0 asserts rst
  // together with that byte instead of delivering it.
  task automatic load(input int gap_mod, input int abort_at);
    int k, cyc;
    bit acc;
    k = 0;
    cyc = 0;
    @(negedge clk_cpu); start = 1'b1;
    @(negedge clk_cpu); start = 1'b0;
    while (k < m_len) begin
      if (k == abort_at) begin
        rst = 1'b1; in_valid = 1'b1; in_data = img_byte(k); acc_idx = -1;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        rst = 1'b0; in_valid = 1'b0;
        return;
      end
      in_valid = !(gap_mod != 0 && $urandom_range(gap_mod - 1) == 0);
      in_data  = img_byte(k);
      acc      = in_valid && in_ready;
      acc_idx  = acc ? k : -1;
      if (acc && k == m_len - 1) chk("done_before_last", {31'd0, done}, 0);
      @(posedge clk_cpu);
      if (acc) k++;
      @(negedge clk_cpu);
      cyc++;
      if (cyc > 2 * m_len + 64) begin
        chk("load_timeout_bytes", k, m_len);
        break;
      end
    end
    in_valid = 1'b0;
    acc_idx  = -1;
    chk("done", {31'd0, done}, {31'd0, m_ok});
    chk("error", {31'd0, error}, {31'd0, !m_ok});
    chk("cart_rst", {31'd0, cart_rst}, {31'd0, !m_ok});
    chk("in_ready_after", {31'd0, in_ready}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    clr_obs();
    m_ok = 1'b0; m_tr = 0; m_prg = 0; m_chr = 0; m_len = 0; m_seed = 8'h00;
    repeat (3) @(posedge clk_cpu);
    @(negedge clk_cpu);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_cart_rst", {31'd0, cart_rst}, 1);
    chk("rst_prg_addr", 32'(prg_addr), 0);
    chk("rst_chr_addr", 32'(chr_addr), 0);
    chk("rst_prg_wdata", 32'(prg_wdata), 0);
    chk("rst_mapper", 32'(mapper), 0);
    chk("rst_mirrorv", {31'd0, mirrorv}, 0);
    chk("rst_prg_banks", 32'(prg_banks), 0);
    chk("rst_chr_banks", 32'(chr_banks), 0);
    start = 1'b1;
    @(negedge clk_cpu);
    start = 1'b0;
    chk("rst_beats_start", {31'd0, in_ready}, 0);
    rst = 1'b0;

    // NROM-256 with vertical mirroring
    set_image(8'h1A, 8'h02, 8'h01, 8'h01, 8'h00, 8'h3C);
    clr_obs();
    load(0, -1);
    chk("n256_prg_writes", n_prg, 32768);
    chk("n256_chr_writes", n_chr, 8192);
    chk("n256_last_prg", last_prg, 32'h7FFF);
    chk("n256_last_chr", last_chr, 32'h1FFF);
    chk("n256_mirrorv", {31'd0, mirrorv}, 1);
    chk("n256_mapper", 32'(mapper), 0);
    chk("n256_prg_banks", 32'(prg_banks), 2);
    chk("n256_chr_banks", 32'(chr_banks), 1);

    // Bad magic byte 3
    set_image(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    clr_obs();
    load(0, -1);
    repeat (5) @(negedge clk_cpu);
    chk("badmagic_error_sticky", {31'd0, error}, 1);
    chk("badmagic_in_ready", {31'd0, in_ready}, 0);
    chk("badmagic_writes", n_prg + n_chr, 0);

    // NROM-128 after the error; hdr7 high nibble lands in mapper[7:4]
    set_image(8'h1A, 8'h01, 8'h00, 8'h00, 8'h30, 8'hA5);
    clr_obs();
    load(0, -1);
    chk("n128_prg_writes", n_prg, 16384);
    chk("n128_last_prg", last_prg, 32'h3FFF);
    chk("n128_chr_writes", n_chr, 0);
    chk("n128_mirrorv", {31'd0, mirrorv}, 0);
    chk("n128_mapper", 32'(mapper), 32'h30);

    // Three PRG banks do not fit a 32 KiB PRG space
    set_image(8'h1A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    clr_obs();
    load(0, -1);
    chk("prg3_writes", n_prg + n_chr, 0);

    // rst arrives with the 1001st PRG byte
    set_image(8'h1A, 8'h01, 8'h01, 8'h01, 8'h00, 8'h11);
    clr_obs();
    load(0, 16 + 1000);
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    chk("abort_cart_rst", {31'd0, cart_rst}, 1);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_prg_banks", 32'(prg_banks), 0);
    repeat (8) @(negedge clk_cpu);
    chk("abort_prg_writes", n_prg, 1000);
    chk("abort_still_idle", {31'd0, in_ready}, 0);

    // Reload: trainer present, no CHR, random input gaps
    set_image(8'h1A, 8'h01, 8'h00, 8'h04, 8'h00, 8'h5A);
    clr_obs();
    load(8, -1);
    chk("trainer_first_prg_data", first_prg_data, 32'h48);
    chk("trainer_prg_writes", n_prg, 16384);
    chk("trainer_last_prg", last_prg, 32'h3FFF);
    chk("trainer_chr_writes", n_chr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
